vga_sync_rx: RTL and testbench

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

---
 rtl/vga_sync_rx_pkg.sv | 23 ++
 rtl/vga_sync_rx_if.sv | 32 +++
 rtl/vga_sync_rx_edge_det.sv | 27 ++
 rtl/vga_sync_rx.sv | 171 +++++++++++++++++
 tb/tb_vga_sync_rx.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/vga_sync_rx_pkg.sv
// Shared VGA timing constants and receiver lock-state encoding.
package vga_sync_rx_pkg;

  localparam int unsigned HPIXELS_DEF     = 800;
  localparam int unsigned VLINES_DEF      = 521;
  localparam int unsigned HPULSE_DEF      = 96;
  localparam int unsigned VPULSE_DEF      = 2;
  localparam int unsigned HBP_DEF         = 144;
  localparam int unsigned HFP_DEF         = 784;
  localparam int unsigned VBP_DEF         = 31;
  localparam int unsigned VFP_DEF         = 511;
  localparam int unsigned LOCK_FRAMES_DEF = 2;

  // Position counters are 10 bits and stop at all-ones.
  localparam logic [9:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED
  } sync_state_e;

endpackage

// File: rtl/vga_sync_rx_if.sv
// Pixel-stream bundle between a VGA source and the sync receiver.
interface vga_sync_rx_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       pix_valid;
  logic [9:0] x;
  logic [9:0] y;
  logic       de;
  logic [2:0] red_o;
  logic [2:0] green_o;
  logic [1:0] blue_o;
  logic       locked;
  logic       frame_start;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output pix_en, hsync, vsync, red, green, blue,
    input  pix_valid, x, y, de, red_o, green_o, blue_o,
    input  locked, frame_start, err, err_cnt
  );

  modport slave (
    input  pix_en, hsync, vsync, red, green, blue,
    output pix_valid, x, y, de, red_o, green_o, blue_o,
    output locked, frame_start, err, err_cnt
  );
endinterface

// File: rtl/vga_sync_rx_edge_det.sv
// Two-stage sampler for one sync line with rise/fall detection on stage two.
module vga_edge_det (
  input  logic clk,
  input  logic clr_n,
  input  logic en_i,
  input  logic d_i,
  output logic fall_o,
  output logic rise_o
);
  logic s1_q, s2_q, prev_q;

  // Shift the sync line in on each strobe; idle level is high.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else if (en_i) begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign fall_o = prev_q & ~s2_q;
  assign rise_o = ~prev_q & s2_q;
endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers position, active area and lock status.
module vga_sync_rx
  import vga_sync_rx_pkg::*;
#(
  parameter int unsigned HPIXELS     = HPIXELS_DEF,
  parameter int unsigned VLINES      = VLINES_DEF,
  parameter int unsigned HPULSE      = HPULSE_DEF,
  parameter int unsigned VPULSE      = VPULSE_DEF,
  parameter int unsigned HBP         = HBP_DEF,
  parameter int unsigned HFP         = HFP_DEF,
  parameter int unsigned VBP         = VBP_DEF,
  parameter int unsigned VFP         = VFP_DEF,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input logic          clk,
  input logic          clr_n,
  vga_sync_rx_if.slave bus
);
  localparam logic [9:0] H_LAST  = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST  = 10'(VLINES - 1);
  localparam logic [9:0] H_PULSE = 10'(HPULSE);
  localparam logic [9:0] V_PULSE = 10'(VPULSE);
  localparam logic [9:0] H_BP    = 10'(HBP);
  localparam logic [9:0] H_FP    = 10'(HFP);
  localparam logic [9:0] V_BP    = 10'(VBP);
  localparam logic [9:0] V_FP    = 10'(VFP);
  localparam logic [7:0] CNT_TOP = 8'(LOCK_FRAMES - 1);

  logic        h_fall, h_rise, v_fall, v_rise;
  logic [7:0]  col1_q, col2_q;
  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  sync_state_e state_q, state_d;
  logic [7:0]  frm_q, frm_d;
  logic        dirty_q, dirty_d, hchk_q, hchk_d, vchk_q, vchk_d;
  logic        viol, de_d;
  logic        pix_valid_q, de_q, locked_q, fs_q, err_q;
  logic [9:0]  x_q, y_q;
  logic [7:0]  col_q, err_cnt_q;

  vga_edge_det u_hs (.clk(clk), .clr_n(clr_n), .en_i(bus.pix_en), .d_i(bus.hsync),
                     .fall_o(h_fall), .rise_o(h_rise));
  vga_edge_det u_vs (.clk(clk), .clr_n(clr_n), .en_i(bus.pix_en), .d_i(bus.vsync),
                     .fall_o(v_fall), .rise_o(v_rise));

  // Colour follows the same two-stage pipe as the syncs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      col1_q <= '0;
      col2_q <= '0;
    end else if (bus.pix_en) begin
      col1_q <= {bus.red, bus.green, bus.blue};
      col2_q <= col1_q;
    end
  end

  // Position counters, violation detection and active-area decode.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (bus.pix_en) begin
      if (h_fall)                hc_d = '0;
      else if (hc_q != CNT_MAX)  hc_d = hc_q + 10'd1;
      if (v_fall)                          vc_d = '0;
      else if (h_fall && vc_q != CNT_MAX)  vc_d = vc_q + 10'd1;
    end
    viol = bus.pix_en && ((h_fall && hchk_q && hc_q != H_LAST) ||
                          (h_rise && hc_d != H_PULSE) ||
                          (v_fall && vchk_q && vc_q != V_LAST) ||
                          (v_rise && vc_d != V_PULSE) ||
                          (hc_d == CNT_MAX && hc_q != CNT_MAX));
    de_d = (hc_d >= H_BP) && (hc_d < H_FP) && (vc_d >= V_BP) && (vc_d < V_FP);
  end

  // Lock FSM; a violation at a vsync fall spoils the ending frame but not the new one.
  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    dirty_d = dirty_q;
    hchk_d  = hchk_q | (bus.pix_en & h_fall);
    vchk_d  = vchk_q | (bus.pix_en & v_fall);
    if (bus.pix_en) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (v_fall) begin
            state_d = ST_ACQUIRE;
            frm_d   = '0;
            dirty_d = 1'b0;
          end
        end
        ST_ACQUIRE: begin
          if (viol) begin
            frm_d   = '0;
            dirty_d = ~v_fall;
          end else if (v_fall) begin
            if (dirty_q)               dirty_d = 1'b0;
            else if (frm_q == CNT_TOP) state_d = ST_LOCKED;
            else                       frm_d   = frm_q + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (viol) begin
            state_d = ST_UNLOCKED;
            hchk_d  = 1'b0;
            vchk_d  = 1'b0;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  // Counter and FSM state registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      state_q <= ST_UNLOCKED;
      frm_q   <= '0;
      dirty_q <= 1'b0;
      hchk_q  <= 1'b0;
      vchk_q  <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      state_q <= state_d;
      frm_q   <= frm_d;
      dirty_q <= dirty_d;
      hchk_q  <= hchk_d;
      vchk_q  <= vchk_d;
    end
  end

  // Registered outputs; pulses last the single clk after the completing strobe.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pix_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      de_q        <= 1'b0;
      col_q       <= '0;
      locked_q    <= 1'b0;
      fs_q        <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      pix_valid_q <= bus.pix_en;
      fs_q        <= bus.pix_en & v_fall;
      err_q       <= viol;
      locked_q    <= (state_d == ST_LOCKED);
      if (viol && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (bus.pix_en) begin
        de_q  <= de_d;
        x_q   <= de_d ? hc_d - H_BP : '0;
        y_q   <= de_d ? vc_d - V_BP : '0;
        col_q <= de_d ? col2_q : '0;
      end
    end
  end

  assign bus.pix_valid   = pix_valid_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.de          = de_q;
  assign bus.red_o       = col_q[7:5];
  assign bus.green_o     = col_q[4:2];
  assign bus.blue_o      = col_q[1:0];
  assign bus.locked      = locked_q;
  assign bus.frame_start = fs_q;
  assign bus.err         = err_q;
  assign bus.err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx using a shrunken frame geometry.
module tb_vga_sync_rx;
  localparam int HP = 40, VL = 12, HPU = 4, VPU = 2;
  localparam int HB = 8, HF = 36, VB = 3, VF = 10, LF = 2;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;

  vga_sync_rx_if bus ();

  vga_sync_rx #(
    .HPIXELS(HP), .VLINES(VL), .HPULSE(HPU), .VPULSE(VPU),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(LF)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         chk_pix;
    logic [9:0] x, y;
    logic       de;
    logic [7:0] col;
    logic       lock, err, fs;
    logic [7:0] ecnt;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;
  int   falls_to_lock = LF + 1;
  int   ecnt_exp = 0;
  bit   aligned = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output side of the scoreboard plus all-zero check while in reset.
  always @(negedge clk) begin
    exp_t e;
    if (!clr_n) begin
      check_eq("rst_outs", {bus.pix_valid, bus.x, bus.y, bus.de, bus.red_o, bus.green_o,
                            bus.blue_o, bus.locked, bus.frame_start, bus.err, bus.err_cnt}, 64'd0);
    end else if (bus.pix_valid) begin
      check_eq("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk_pix) begin
          check_eq("x", bus.x, e.x);
          check_eq("y", bus.y, e.y);
          check_eq("de", bus.de, e.de);
          check_eq("colour", {bus.red_o, bus.green_o, bus.blue_o}, e.col);
        end
        check_eq("locked", bus.locked, e.lock);
        check_eq("err", bus.err, e.err);
        check_eq("frame_start", bus.frame_start, e.fs);
        check_eq("err_cnt", bus.err_cnt, e.ecnt);
      end
    end
  end

  // Two idle samples emerge from the freshly reset pipe before real pixels.
  task automatic push_idle();
    exp_t e;
    e.chk_pix = 1; e.x = '0; e.y = '0; e.de = 0; e.col = '0;
    e.lock = 0; e.err = 0; e.fs = 0; e.ecnt = '0;
    q.push_back(e);
    q.push_back(e);
  endtask

  task automatic do_reset();
    #1;
    q.delete();
    clr_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 clr_n = 1'b1;
    aligned       = 0;
    falls_to_lock = LF + 1;
    ecnt_exp      = 0;
    push_idle();
  endtask

  task automatic emit(input int gh, input int gv, input bit hs, input bit vs, input bit bad);
    exp_t       e;
    logic [7:0] col;
    bit         act;
    col = (gh == HB && gv == VB) ? 8'hFF : 8'($urandom);
    if (gh == 0 && gv == 0) begin
      aligned = 1;
      if (falls_to_lock > 0) falls_to_lock--;
    end
    if (bad) begin
      falls_to_lock = LF + 1;
      if (ecnt_exp != 255) ecnt_exp++;
    end
    act       = (gh >= HB) && (gh < HF) && (gv >= VB) && (gv < VF);
    e.chk_pix = aligned;
    e.de      = act;
    e.x       = act ? 10'(gh - HB) : '0;
    e.y       = act ? 10'(gv - VB) : '0;
    e.col     = act ? col : '0;
    e.lock    = (falls_to_lock == 0);
    e.err     = bad;
    e.fs      = (gh == 0 && gv == 0);
    e.ecnt    = 8'(ecnt_exp);
    q.push_back(e);
    bus.hsync = hs;
    bus.vsync = vs;
    {bus.red, bus.green, bus.blue} = col;
    bus.pix_en = 1'b1;
    @(posedge clk);
    #1 bus.pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One frame, optionally with a short line, a stuck-high hsync, a wide vsync or a mid-line reset.
  task automatic send_frame(input int short_line, input int hold_line, input int vs_lines,
                            input int rst_line);
    for (int gv = 0; gv < VL; gv++) begin
      int len;
      len = HP;
      if (gv == short_line) len = HP - 1;
      if (gv == hold_line)  len = HP + 1100;
      for (int gh = 0; gh < len; gh++) begin
        bit bad;
        if (gv == rst_line && gh == 20) do_reset();
        bad = (short_line >= 0 && gv == short_line + 1 && gh == 0) ||
              (gv == hold_line && gh == 1023) ||
              (vs_lines != VPU && gv == vs_lines && gh == 0);
        emit(gh, gv, gh >= HPU, gv >= vs_lines, bad);
      end
    end
  endtask

  initial begin
    bus.pix_en = 1'b0;
    bus.hsync  = 1'b1;
    bus.vsync  = 1'b1;
    bus.red    = '0;
    bus.green  = '0;
    bus.blue   = '0;
    do_reset();
    repeat (4) send_frame(-1, -1, VPU, -1);
    send_frame(6, -1, VPU, -1);
    repeat (3) send_frame(-1, -1, VPU, -1);
    send_frame(-1, 5, VPU, -1);
    repeat (3) send_frame(-1, -1, VPU, -1);
    send_frame(-1, -1, 3, -1);
    repeat (3) send_frame(-1, -1, VPU, -1);
    send_frame(-1, -1, VPU, 5);
    repeat (3) send_frame(-1, -1, VPU, -1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("sb_left", q.size(), 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end
endmodule
